// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends 8 data bits LSB first, with an optional
// parity bit and one stop bit. The line idles high.
// Bit timing comes from a clock-enable style baud counter, so no derived
// clock is generated.
//
// Parameters
//   SYSTEM_CLK  input clock frequency in Hz
//   BAUDRATE    serial bit rate; CLKS_PER_BIT = SYSTEM_CLK / BAUDRATE (2..65535)
//   PARITY_EN   1 inserts a parity bit between the data bits and the stop bit
//   PARITY_ODD  0 selects even parity, 1 selects odd parity
//
// Ports
//   clk       system clock; all logic is on the rising edge
//   rst       synchronous reset, active high
//   tx_data   byte to send; latched when the byte is accepted
//   tx_valid  request to send tx_data
//   tx_ready  high when a byte can be accepted this cycle (IDLE and not in reset)
//   tx        serial line output (registered, idle high)
//   tx_busy   high while a frame is in progress
//   tx_done   one-cycle pulse in the cycle after the stop bit completes
module uart_tx #(
  parameter int SYSTEM_CLK = 1000000,
  parameter int BAUDRATE   = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int          CLKS_PER_BIT   = SYSTEM_CLK / BAUDRATE;
  localparam logic [15:0] BAUD_LAST      = 16'(CLKS_PER_BIT - 1);
  localparam logic        PARITY_ODD_BIT = (PARITY_ODD != 0);
  localparam logic        PARITY_EN_BIT  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;

  logic bit_end;
  logic parity_bit;

  assign bit_end = (baud_q == BAUD_LAST);

  // Parity comes from the byte latched at accept, not from the shift
  // register, which has been emptied by the time the parity bit goes out.
  assign parity_bit = (^data_q) ^ PARITY_ODD_BIT;

  // Next-state logic. tx_d is the value the line takes in the next cycle,
  // so every change of bit is decided one edge ahead and the line itself
  // comes straight from a flop. A bit ends when the baud counter reaches
  // CLKS_PER_BIT-1, which makes every bit exactly CLKS_PER_BIT cycles long.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d    = 16'd0;
        bit_cnt_d = 3'd0;
        tx_d      = 1'b1;
        // Reset has priority in the flop block, so tx_valid alone is the
        // accept condition here.
        if (tx_valid) begin
          state_d = START;
          shift_d = tx_data;
          data_d  = tx_data;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          baud_d    = 16'd0;
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 3'd0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      DATA: begin
        // bit_cnt_q counts the data bits already placed on the line, minus one.
        if (bit_end) begin
          baud_d = 16'd0;
          if (bit_cnt_q == 3'd7) begin
            if (PARITY_EN_BIT) begin
              state_d = PARITY;
              tx_d    = parity_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      PARITY: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = 16'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register. Reset abandons any partial frame: the line goes high,
  // the FSM returns to IDLE and no tx_done is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready = (state_q == IDLE) & ~rst;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx.
// Four instances: plain 8N1, even parity and odd parity, all at
// CLKS_PER_BIT=4, plus one at the default parameters (CLKS_PER_BIT=104).
// The default instance is decoded by a small behavioural receiver.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       txValid [4];
  logic [7:0] txData  [4];
  logic       txReady [4];
  logic       txLine  [4];
  logic       txBusy  [4];
  logic       txDone  [4];

  int passCount  = 0;
  int totalCount = 0;

  typedef struct {
    string       name;
    int          idx;
    int          cpb;
    logic [7:0]  data;
    logic [10:0] frame;
    int          nbits;
  } vector_t;

  vector_t vectors [4];

  // Plain 8N1 instance at CLKS_PER_BIT = 4.
  uart_tx #(.SYSTEM_CLK(16), .BAUDRATE(4), .PARITY_EN(0), .PARITY_ODD(0)) dutPlain (
    .clk(clk), .rst(rst), .tx_data(txData[0]), .tx_valid(txValid[0]),
    .tx_ready(txReady[0]), .tx(txLine[0]), .tx_busy(txBusy[0]), .tx_done(txDone[0]));

  // Even parity instance.
  uart_tx #(.SYSTEM_CLK(16), .BAUDRATE(4), .PARITY_EN(1), .PARITY_ODD(0)) dutEven (
    .clk(clk), .rst(rst), .tx_data(txData[1]), .tx_valid(txValid[1]),
    .tx_ready(txReady[1]), .tx(txLine[1]), .tx_busy(txBusy[1]), .tx_done(txDone[1]));

  // Odd parity instance.
  uart_tx #(.SYSTEM_CLK(16), .BAUDRATE(4), .PARITY_EN(1), .PARITY_ODD(1)) dutOdd (
    .clk(clk), .rst(rst), .tx_data(txData[2]), .tx_valid(txValid[2]),
    .tx_ready(txReady[2]), .tx(txLine[2]), .tx_busy(txBusy[2]), .tx_done(txDone[2]));

  // Default parameters (CLKS_PER_BIT = 104).
  uart_tx dutDefault (
    .clk(clk), .rst(rst), .tx_data(txData[3]), .tx_valid(txValid[3]),
    .tx_ready(txReady[3]), .tx(txLine[3]), .tx_busy(txBusy[3]), .tx_done(txDone[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    totalCount++;
    if (actual !== required)
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    else
      passCount++;
  endtask

  // Present a byte and return just after the accept edge.
  task automatic applyStimulus(input int idx, input logic [7:0] data);
    @(negedge clk);
    txData[idx]  = data;
    txValid[idx] = 1'b1;
    check($sformatf("ready before accept dut%0d", idx), 32'(txReady[idx]), 32'd1);
    @(posedge clk);
  endtask

  // Check a frame cycle by cycle from the cycle after the accept edge,
  // then the tx_done cycle. Optionally keeps tx_valid high (back-to-back)
  // and/or drives a second byte at cycle injectAt.
  task automatic checkOutput(input string name, input int idx, input int cpb,
                             input logic [10:0] frame, input int nbits,
                             input bit keepValid, input int injectAt,
                             input logic [7:0] injectData);
    int   badBits;
    int   badCtrl;
    int   n;
    logic expBit;
    badCtrl = 0;
    for (int b = 0; b < nbits; b++) begin
      expBit  = frame[b];
      badBits = 0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        n = b * cpb + c + 1;
        if (n == 1 && !keepValid) txValid[idx] = 1'b0;
        if (injectAt != 0 && n == injectAt) begin
          txValid[idx] = 1'b1;
          txData[idx]  = injectData;
        end
        if (injectAt != 0 && n == injectAt + 1 && !keepValid) txValid[idx] = 1'b0;
        if (txLine[idx] !== expBit) badBits++;
        if (txBusy[idx] !== 1'b1 || txDone[idx] !== 1'b0 || txReady[idx] !== 1'b0) badCtrl++;
      end
      check($sformatf("%s bit%0d bad cycles", name, b), 32'(badBits), 32'd0);
    end
    check($sformatf("%s busy/done/ready during frame bad cycles", name), 32'(badCtrl), 32'd0);
    @(negedge clk);
    check($sformatf("%s tx_done at %0d cycles", name, nbits * cpb), 32'(txDone[idx]), 32'd1);
    check($sformatf("%s tx_ready in done cycle", name), 32'(txReady[idx]), 32'd1);
    check($sformatf("%s tx idle in done cycle", name), 32'(txLine[idx]), 32'd1);
    check($sformatf("%s busy low in done cycle", name), 32'(txBusy[idx]), 32'd0);
  endtask

  // Behavioural receiver for the default instance: samples mid-bit.
  task automatic receiveByte(input logic [7:0] sent);
    int         waited;
    logic [7:0] got;
    bit         found;
    applyStimulus(3, sent);
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 20) begin
      @(negedge clk);
      txValid[3] = 1'b0;
      waited++;
      if (txLine[3] === 1'b0) found = 1'b1;
    end
    check($sformatf("rx %02h start edge seen", sent), 32'(found), 32'd1);
    if (found) begin
      repeat (52) @(negedge clk);
      check($sformatf("rx %02h start mid", sent), 32'(txLine[3]), 32'd0);
      got = 8'd0;
      for (int b = 0; b < 8; b++) begin
        repeat (104) @(negedge clk);
        got[b] = txLine[3];
      end
      check($sformatf("rx %02h data_out", sent), 32'(got), 32'(sent));
      repeat (104) @(negedge clk);
      check($sformatf("rx %02h stop mid", sent), 32'(txLine[3]), 32'd1);
      found  = 1'b0;
      waited = 0;
      while (!found && waited < 208) begin
        @(negedge clk);
        waited++;
        if (txDone[3] === 1'b1) found = 1'b1;
      end
      check($sformatf("rx %02h tx_done seen", sent), 32'(found), 32'd1);
    end
  endtask

  initial begin
    int badIdle;

    // Frames are listed LSB first: bit 0 is the start bit.
    vectors[0] = '{"plain A5", 0, 4, 8'hA5, 11'b0_1_10100101_0, 10};
    vectors[1] = '{"even 07",  1, 4, 8'h07, 11'b1_1_00000111_0, 11};
    vectors[2] = '{"odd 07",   2, 4, 8'h07, 11'b1_0_00000111_0, 11};
    vectors[3] = '{"plain 3C", 0, 4, 8'h3C, 11'b0_1_00111100_0, 10};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      txValid[i] = 1'b0;
      txData[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset tx dut%0d", i),    32'(txLine[i]),  32'd1);
      check($sformatf("reset busy dut%0d", i),  32'(txBusy[i]),  32'd0);
      check($sformatf("reset done dut%0d", i),  32'(txDone[i]),  32'd0);
      check($sformatf("reset ready dut%0d", i), 32'(txReady[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("ready after reset dut%0d", i), 32'(txReady[i]), 32'd1);

    $display("[TB] table vectors");
    foreach (vectors[v]) begin
      applyStimulus(vectors[v].idx, vectors[v].data);
      checkOutput(vectors[v].name, vectors[v].idx, vectors[v].cpb,
                  vectors[v].frame, vectors[v].nbits, 1'b0, 0, 8'h00);
      @(negedge clk);
      check($sformatf("%s tx_done single pulse", vectors[v].name), 32'(txDone[vectors[v].idx]), 32'd0);
    end

    $display("[TB] back-to-back 00 then FF");
    applyStimulus(0, 8'h00);
    checkOutput("b2b 00", 0, 4, 11'b0_1_00000000_0, 10, 1'b1, 1, 8'hFF);
    checkOutput("b2b FF", 0, 4, 11'b0_1_11111111_0, 10, 1'b0, 0, 8'h00);

    $display("[TB] mid-frame valid ignored");
    applyStimulus(0, 8'h81);
    checkOutput("ignore 3C in 81", 0, 4, 11'b0_1_10000001_0, 10, 1'b0, 10, 8'h3C);
    @(negedge clk);
    check("no frame after ignored byte", 32'(txBusy[0]), 32'd0);

    $display("[TB] reset during data bit 3");
    applyStimulus(0, 8'h00);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1) txValid[0] = 1'b0;
    end
    check("tx low in data bit3", 32'(txLine[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset tx", 32'(txLine[0]), 32'd1);
    check("mid reset busy", 32'(txBusy[0]), 32'd0);
    check("mid reset ready", 32'(txReady[0]), 32'd0);
    rst = 1'b0;
    badIdle = 0;
    repeat (60) begin
      @(negedge clk);
      if (txLine[0] !== 1'b1 || txDone[0] !== 1'b0 || txBusy[0] !== 1'b0) badIdle++;
    end
    check("after mid reset idle bad cycles", 32'(badIdle), 32'd0);
    applyStimulus(0, 8'h55);
    checkOutput("post reset 55", 0, 4, 11'b0_1_01010101_0, 10, 1'b0, 0, 8'h00);

    $display("[TB] reset with valid");
    @(negedge clk);
    rst        = 1'b1;
    txValid[0] = 1'b1;
    txData[0]  = 8'h12;
    @(negedge clk);
    check("rst+valid busy", 32'(txBusy[0]), 32'd0);
    check("rst+valid tx", 32'(txLine[0]), 32'd1);
    check("rst+valid ready", 32'(txReady[0]), 32'd0);
    rst        = 1'b0;
    txValid[0] = 1'b0;
    @(negedge clk);
    check("rst+valid nothing accepted", 32'(txBusy[0]), 32'd0);

    $display("[TB] loopback at default parameters");
    receiveByte(8'h00);
    receiveByte(8'h55);
    receiveByte(8'hAA);
    receiveByte(8'hFF);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
